// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter                                                               |
// | Shares the byte-wide RAM port between I-cache line fills and load/store  |
// | accesses. Optional MEM_ARB_LS_PRIORITY_EN: load/store always wins ties.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int         LINE_WORDS = 16,
  parameter logic [1:0] IO_HI      = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_data,
  output logic        ic_data_valid,
  output logic [3:0]  ic_word_idx,
  output logic        ic_done,
  input  logic        clear,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int c_OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int c_CNT_W = c_OFF_W + 1;
  localparam logic [c_CNT_W-1:0] c_LINE_BYTES = c_CNT_W'(4 * LINE_WORDS);
  localparam logic [31:0]        c_LINE_MASK  = 32'(4 * LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IC_RD = 3'd1,
    S_LS_RD = 3'd2,
    S_LS_WR = 3'd3,
    S_TURN  = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_last_ic;
  logic [31:0]          r_base;
  logic [c_CNT_W-1:0]   r_len;
  logic [c_CNT_W-1:0]   r_iss;
  logic [c_CNT_W-1:0]   r_cap;
  logic                 r_v0;
  logic                 r_v1;
  logic                 r_resume;
  logic                 r_io;
  logic [31:0]          r_wdata;
  logic [31:0]          r_buf;

  logic [31:0]          r_ic_data;
  logic                 r_ic_valid;
  logic [3:0]           r_ic_idx;
  logic                 r_ic_done;
  logic [31:0]          r_ls_rdata;
  logic                 r_ls_done;
  logic [7:0]           r_dout;
  logic [31:0]          r_a;
  logic                 r_wr;

  logic                 w_ic_ok;
  logic                 w_tie;
  logic                 w_grant_ls;
  logic                 w_grant_ic;
  logic [c_CNT_W-1:0]   w_ls_len;
  logic [4:0]           w_bsel;
  logic [31:0]          w_word;
  logic [7:0]           w_wbyte;
  logic [3:0]           w_widx;
  logic                 w_last;
  logic                 w_io_now;

  assign w_ic_ok = ic_req & ~clear;
  assign w_tie   = w_ic_ok & ls_req;

`ifdef MEM_ARB_LS_PRIORITY_EN
  assign w_grant_ls = ls_req;
`else
  // On a tie the side that did not win the previous tie is served.
  assign w_grant_ls = ls_req & (~w_ic_ok | r_last_ic);
`endif
  assign w_grant_ic = w_ic_ok & ~w_grant_ls;

  always_comb begin
    w_ls_len = c_CNT_W'(4);
    case (ls_size)
      2'd0:    w_ls_len = c_CNT_W'(1);
      2'd1:    w_ls_len = c_CNT_W'(2);
      default: w_ls_len = c_CNT_W'(4);
    endcase
  end

  assign w_bsel   = {r_cap[1:0], 3'b000};
  assign w_wbyte  = r_wdata[{r_iss[1:0], 3'b000} +: 8];
  assign w_widx   = 4'(r_cap >> 2);
  assign w_last   = (r_cap == r_len - 1'b1);
  assign w_io_now = (ls_addr[17:16] == IO_HI) & io_buffer_full;

  always_comb begin
    w_word = r_buf;
    w_word[w_bsel +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_ic  <= 1'b1;
      r_base     <= '0;
      r_len      <= '0;
      r_iss      <= '0;
      r_cap      <= '0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_resume   <= 1'b0;
      r_io       <= 1'b0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_ic_data  <= '0;
      r_ic_valid <= 1'b0;
      r_ic_idx   <= '0;
      r_ic_done  <= 1'b0;
      r_ls_rdata <= '0;
      r_ls_done  <= 1'b0;
      r_dout     <= '0;
      r_a        <= '0;
      r_wr       <= 1'b0;
    end else if (!rdy) begin
      // Data in the read pipeline is stale after a stall; reissue on resume.
      if (r_state == S_IC_RD || r_state == S_LS_RD) r_resume <= 1'b1;
    end else begin
      r_ic_valid <= 1'b0;
      r_ic_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_resume <= 1'b0;
          r_v0     <= 1'b0;
          r_v1     <= 1'b0;
          if (w_grant_ls) begin
            if (w_tie) r_last_ic <= 1'b0;
            r_base  <= ls_addr;
            r_len   <= w_ls_len;
            r_wdata <= ls_wdata;
            r_io    <= (ls_addr[17:16] == IO_HI);
            r_cap   <= '0;
            r_buf   <= '0;
            r_a     <= ls_addr;
            if (ls_we) begin
              r_state <= S_LS_WR;
              if (w_io_now) begin
                r_iss <= '0;
                r_wr  <= 1'b0;
              end else begin
                r_iss  <= c_CNT_W'(1);
                r_dout <= ls_wdata[7:0];
                r_wr   <= 1'b1;
              end
            end else begin
              r_state <= S_LS_RD;
              r_iss   <= c_CNT_W'(1);
              r_v0    <= 1'b1;
            end
          end else if (w_grant_ic) begin
            if (w_tie) r_last_ic <= 1'b1;
            r_state <= S_IC_RD;
            r_base  <= ic_addr & ~c_LINE_MASK;
            r_a     <= ic_addr & ~c_LINE_MASK;
            r_len   <= c_LINE_BYTES;
            r_iss   <= c_CNT_W'(1);
            r_cap   <= '0;
            r_v0    <= 1'b1;
          end
        end

        S_IC_RD, S_LS_RD: begin
          if (r_state == S_IC_RD && clear) begin
            r_a     <= '0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_state <= S_TURN;
          end else if (r_resume) begin
            r_resume <= 1'b0;
            r_v1     <= 1'b0;
            if (r_cap < r_len) begin
              r_a   <= r_base + 32'(r_cap);
              r_iss <= r_cap + 1'b1;
              r_v0  <= 1'b1;
            end else begin
              r_v0 <= 1'b0;
            end
          end else begin
            r_v1 <= r_v0;
            // mem_a is held on the last byte once every address is issued.
            if (r_iss < r_len) begin
              r_a   <= r_base + 32'(r_iss);
              r_iss <= r_iss + 1'b1;
              r_v0  <= 1'b1;
            end else begin
              r_v0 <= 1'b0;
            end
            if (r_v1) begin
              r_buf <= w_word;
              r_cap <= r_cap + 1'b1;
              if (r_state == S_IC_RD) begin
                if (r_cap[1:0] == 2'b11) begin
                  r_ic_data  <= w_word;
                  r_ic_valid <= 1'b1;
                  r_ic_idx   <= w_widx;
                end
                if (w_last) begin
                  r_ic_done <= 1'b1;
                  r_a       <= '0;
                  r_state   <= S_TURN;
                end
              end else if (w_last) begin
                r_ls_rdata <= w_word;
                r_ls_done  <= 1'b1;
                r_a        <= '0;
                r_state    <= S_TURN;
              end
            end
          end
        end

        S_LS_WR: begin
          if (r_iss == r_len) begin
            r_wr      <= 1'b0;
            r_a       <= '0;
            r_dout    <= '0;
            r_ls_done <= 1'b1;
            r_state   <= S_TURN;
          end else if (r_io && io_buffer_full) begin
            r_wr <= 1'b0;
          end else begin
            r_a    <= r_base + 32'(r_iss);
            r_dout <= w_wbyte;
            r_wr   <= 1'b1;
            r_iss  <= r_iss + 1'b1;
          end
        end

        S_TURN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ic_data       = r_ic_data;
  assign ic_data_valid = r_ic_valid;
  assign ic_word_idx   = r_ic_idx;
  assign ic_done       = r_ic_done;
  assign ls_rdata      = r_ls_rdata;
  assign ls_done       = r_ls_done;
  assign mem_dout      = r_dout;
  assign mem_a         = r_a;
  assign mem_wr        = r_wr & rdy;

endmodule
`default_nettype wire
